// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached burst RAM: opcodes, output FSM states,
// and the address-beat helper. Optional parity build: SPI_RAM_PARITY_EN.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } out_state_e;

  // Number of chunk beats needed to load a full pointer, MS chunk first.
  function automatic int addr_beats(input int addr_size, input int chunk_width);
    return (addr_size + chunk_width - 1) / chunk_width;
  endfunction

endpackage

// File: rtl/spi_ram_addr_ptr.sv
// Address pointer: chunk-shift load, optional auto-increment, wrap at MEM_DEPTH.
// The stored value may exceed MEM_DEPTH; the exported address is reduced once.
module spi_ram_addr_ptr
  import spi_ram_pkg::*;
#(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_SIZE = 10,
  parameter int AUTO_INC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [MEM_WIDTH-1:0] chunk_i,
  input  logic                 inc_i,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 in_range_o
);

  localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] ONE_W   = (ADDR_SIZE + 1)'(1);

  logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
  logic [ADDR_SIZE-1:0] load_val;
  logic [ADDR_SIZE:0]   ptr_ext, eff_ext, nxt_ext;

  generate
    if (ADDR_SIZE > MEM_WIDTH) begin : g_wide
      assign load_val = {ptr_q[ADDR_SIZE-MEM_WIDTH-1:0], chunk_i};
    end else begin : g_narrow
      assign load_val = chunk_i[ADDR_SIZE-1:0];
    end
  endgenerate

  always_comb begin
    ptr_ext = {1'b0, ptr_q};
    eff_ext = (ptr_ext >= DEPTH_W) ? ptr_ext - DEPTH_W : ptr_ext;
    nxt_ext = eff_ext + ONE_W;
    ptr_d   = ptr_q;
    if (load_i) begin
      ptr_d = load_val;
    end else if (inc_i && (AUTO_INC != 0)) begin
      ptr_d = (nxt_ext >= DEPTH_W) ? '0 : nxt_ext[ADDR_SIZE-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign addr_o     = eff_ext[ADDR_SIZE-1:0];
  // Loads >= 2*MEM_DEPTH stay out of range after one reduction; gate accesses.
  assign in_range_o = (eff_ext < DEPTH_W);

endmodule

// File: rtl/spi_ram_burst_ctrl.sv
// Command-decoded single-port RAM behind an SPI slave, with burst pointers and a
// tx_valid/tx_ready output stage. SPI_RAM_PARITY_EN adds per-word even parity.
module spi_ram_burst_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_SIZE = 10,
  parameter int AUTO_INC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEM_WIDTH+1:0] din,
  input  logic                 rx_valid,
  input  logic                 tx_ready,
  input  logic                 err_clr,
`ifdef SPI_RAM_PARITY_EN
  input  logic                 inj_par,
  output logic                 parity_err,
`endif
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 tx_valid,
  output logic                 rd_overrun
);

`ifdef SPI_RAM_PARITY_EN
  localparam int WORD_W = MEM_WIDTH + 1;
`else
  localparam int WORD_W = MEM_WIDTH;
`endif

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  logic [1:0]           opcode;
  logic [MEM_WIDTH-1:0] payload;
  logic                 cmd_valid;
  logic                 wr_cmd, rd_cmd, ld_wr, ld_rd;
  logic                 rd_accept, ovr_set;
  out_state_e           state_q, state_d;
  logic [MEM_WIDTH-1:0] dout_q;
  logic                 ovr_q;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 wr_ok, rd_ok;
  logic [WORD_W-1:0]    wr_word;

  assign opcode    = din[MEM_WIDTH+1:MEM_WIDTH];
  assign payload   = din[MEM_WIDTH-1:0];
  assign cmd_valid = rx_valid && !rst;
  assign ld_wr     = cmd_valid && (opcode == OP_WR_ADDR);
  assign ld_rd     = cmd_valid && (opcode == OP_RD_ADDR);
  assign wr_cmd    = cmd_valid && (opcode == OP_WR_DATA);
  assign rd_cmd    = cmd_valid && (opcode == OP_RD_DATA);

  spi_ram_addr_ptr #(
    .MEM_WIDTH(MEM_WIDTH), .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE), .AUTO_INC(AUTO_INC)
  ) u_wr_ptr (
    .clk(clk), .rst(rst), .load_i(ld_wr), .chunk_i(payload),
    .inc_i(wr_cmd), .addr_o(wr_addr), .in_range_o(wr_ok)
  );

  spi_ram_addr_ptr #(
    .MEM_WIDTH(MEM_WIDTH), .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE), .AUTO_INC(AUTO_INC)
  ) u_rd_ptr (
    .clk(clk), .rst(rst), .load_i(ld_rd), .chunk_i(payload),
    .inc_i(rd_accept), .addr_o(rd_addr), .in_range_o(rd_ok)
  );

  // A read is taken when nothing is pending or the pending word leaves this cycle.
  always_comb begin
    state_d   = state_q;
    rd_accept = 1'b0;
    ovr_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_cmd) begin
          rd_accept = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (tx_ready) begin
          if (rd_cmd) begin
            rd_accept = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (rd_cmd) begin
          ovr_set = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (err_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

`ifdef SPI_RAM_PARITY_EN
  logic par_err_q;
  assign wr_word    = {(^payload) ^ inj_par, payload};
  assign parity_err = par_err_q;
`else
  assign wr_word = payload;
`endif

  always_ff @(posedge clk) begin
    if (wr_cmd && wr_ok) begin
      mem[wr_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
`ifdef SPI_RAM_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      if (rd_accept) begin
        dout_q <= rd_ok ? mem[rd_addr][MEM_WIDTH-1:0] : '0;
      end
`ifdef SPI_RAM_PARITY_EN
      par_err_q <= rd_accept && rd_ok && (^mem[rd_addr]);
`endif
    end
  end

  assign dout       = dout_q;
  assign tx_valid   = (state_q == HOLD);
  assign rd_overrun = ovr_q;

endmodule

// File: tb/tb_spi_ram_burst_ctrl.sv
// Randomised scoreboard bench for spi_ram_burst_ctrl against a behavioural RAM model.
module tb_spi_ram_burst_ctrl;
  import spi_ram_pkg::*;

  localparam int MW    = 8;
  localparam int DEPTH = 1024;
  localparam int AS    = 10;
  localparam int AMASK = (1 << AS) - 1;

  logic          clk = 1'b0;
  logic          rst, rx_valid, tx_ready, err_clr, inj_par;
  logic [MW+1:0] din;
  logic [MW-1:0] dout;
  logic          tx_valid, rd_overrun;
`ifdef SPI_RAM_PARITY_EN
  logic          parity_err;
`endif

  spi_ram_burst_ctrl #(
    .MEM_WIDTH(MW), .MEM_DEPTH(DEPTH), .ADDR_SIZE(AS), .AUTO_INC(1)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .tx_ready(tx_ready), .err_clr(err_clr),
`ifdef SPI_RAM_PARITY_EN
    .inj_par(inj_par), .parity_err(parity_err),
`endif
    .dout(dout), .tx_valid(tx_valid), .rd_overrun(rd_overrun)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic       mon_en = 1'b0;

  int         mem_m [DEPTH];
  bit         bad_m [DEPTH];
  int         wr_p, rd_p;
  bit         exp_pend, exp_ovr, exp_perr;
  int         exp_dout;
  int         sb_q [$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // One cycle of stimulus; the model then advances by the documented command rules.
  task automatic step(input logic rs, input logic rv, input logic [1:0] op,
                      input logic [MW-1:0] pl, input logic tr, input logic clr,
                      input logic ip);
    bit was_pend, took, oset;
    rst = rs; rx_valid = rv; din = {op, pl}; tx_ready = tr; err_clr = clr; inj_par = ip;
    @(posedge clk);
    was_pend = exp_pend;
    took = 0;
    oset = 0;
    exp_perr = 0;
    if (rs) begin
      exp_pend = 0; exp_ovr = 0; exp_dout = 0; wr_p = 0; rd_p = 0;
      sb_q.delete();
    end else begin
      if (rv) begin
        case (op)
          OP_WR_ADDR: wr_p = ((wr_p << MW) | int'(pl)) & AMASK;
          OP_RD_ADDR: rd_p = ((rd_p << MW) | int'(pl)) & AMASK;
          OP_WR_DATA: begin
            mem_m[wr_p % DEPTH] = int'(pl);
            bad_m[wr_p % DEPTH] = ip;
            wr_p = (wr_p % DEPTH + 1) % DEPTH;
          end
          default: begin
            if (!was_pend || tr) begin
              took     = 1;
              exp_dout = mem_m[rd_p % DEPTH];
              exp_perr = bad_m[rd_p % DEPTH];
              sb_q.push_back(exp_dout);
              rd_p     = (rd_p % DEPTH + 1) % DEPTH;
            end else begin
              oset = 1;
            end
          end
        endcase
      end
      if (took) exp_pend = 1;
      else if (was_pend && tr) exp_pend = 0;
      if (oset) exp_ovr = 1;
      else if (clr) exp_ovr = 0;
    end
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [MW-1:0] pl, input logic tr);
    step(1'b0, 1'b1, op, pl, tr, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic tr, input logic clr);
    step(1'b0, 1'b0, OP_RD_DATA, '0, tr, clr, 1'b0);
  endtask

  task automatic load_addr(input logic [1:0] op, input int addr);
    logic [MW-1:0] chunk;
    for (int b = addr_beats(AS, MW) - 1; b >= 0; b--) begin
      chunk = MW'(addr >> (MW * b));
      cmd(op, chunk, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, exp_pend});
      chk("rd_overrun", {31'b0, rd_overrun}, {31'b0, exp_ovr});
      chk("dout", {24'b0, dout}, exp_dout);
`ifdef SPI_RAM_PARITY_EN
      chk("parity_err", {31'b0, parity_err}, {31'b0, exp_perr});
`endif
      if (tx_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_word: got %0h with no expected word queued at %0t", dout, $time);
        end else begin
          chk("sb_word", {24'b0, dout}, sb_q[0]);
          if (tx_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0; err_clr = 1'b0; inj_par = 1'b0;
    din = '0;
    exp_pend = 0; exp_ovr = 0; exp_perr = 0; exp_dout = 0; wr_p = 0; rd_p = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = 0;
      bad_m[i] = 0;
    end

    step(1'b1, 1'b0, OP_WR_ADDR, '0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    step(1'b1, 1'b0, OP_WR_ADDR, '0, 1'b0, 1'b0, 1'b0);

    // Fill the whole array so every later read has a known answer.
    load_addr(OP_WR_ADDR, 0);
    for (int i = 0; i < DEPTH; i++) cmd(OP_WR_DATA, MW'($urandom), 1'b1);

    // Burst write across the top of the array and wrap to 0.
    cmd(OP_WR_ADDR, 8'h03, 1'b1);
    cmd(OP_WR_ADDR, 8'hFE, 1'b1);
    cmd(OP_WR_DATA, 8'hA1, 1'b1);
    cmd(OP_WR_DATA, 8'hB2, 1'b1);
    cmd(OP_WR_DATA, 8'hC3, 1'b1);

    // Streaming burst read, one word per cycle.
    cmd(OP_RD_ADDR, 8'h03, 1'b1);
    cmd(OP_RD_ADDR, 8'hFE, 1'b1);
    repeat (3) cmd(OP_RD_DATA, '0, 1'b1);
    idle(1'b1, 1'b0);

    // Overrun while held, then drain, clear, and set-beats-clear.
    cmd(OP_RD_DATA, '0, 1'b0);
    cmd(OP_RD_DATA, '0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);
    cmd(OP_RD_DATA, '0, 1'b0);
    step(1'b0, 1'b1, OP_RD_DATA, '0, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b1);

    // Reset while holding a word; memory must survive.
    cmd(OP_RD_DATA, '0, 1'b0);
    step(1'b1, 1'b0, OP_RD_DATA, '0, 1'b0, 1'b0, 1'b0);
    cmd(OP_RD_DATA, '0, 1'b1);
    load_addr(OP_RD_ADDR, 10'h3FE);
    cmd(OP_RD_DATA, '0, 1'b1);
    idle(1'b1, 1'b0);

    // Commands without rx_valid are ignored.
    repeat (10) idle(1'b1, 1'b0);
    cmd(OP_RD_DATA, '0, 1'b1);
    idle(1'b1, 1'b0);

    // Parity: injected bad word followed by a clean copy of the same value.
    load_addr(OP_WR_ADDR, 10'h100);
    step(1'b0, 1'b1, OP_WR_DATA, 8'h5A, 1'b1, 1'b0, 1'b1);
    cmd(OP_WR_DATA, 8'h5A, 1'b1);
    load_addr(OP_RD_ADDR, 10'h100);
    cmd(OP_RD_DATA, '0, 1'b1);
    cmd(OP_RD_DATA, '0, 1'b1);
    idle(1'b1, 1'b0);

    // Read immediately after write to the same address.
    load_addr(OP_WR_ADDR, 10'h055);
    load_addr(OP_RD_ADDR, 10'h055);
    cmd(OP_WR_DATA, 8'h3C, 1'b1);
    cmd(OP_RD_DATA, '0, 1'b1);
    idle(1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 8),
           2'($urandom),
           MW'($urandom),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0));
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
